// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, default width.
package muldiv_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = muldiv_pkg::WIDTH
);
  // start is a one-shot request taken only when busy=0 (no ready/queueing);
  // done pulses for one cycle when hi/lo have just been updated.
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_core.sv
// One radix-2 step on the {upper, lower} accumulator: shift-add multiply or restoring divide.
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (is_div) begin
      // a borrow out of diff means the partial remainder is smaller than the divisor
      acc_nxt = diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: FSM, sign handling and atomic HI/LO update.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational MULT/MULTU.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus,
  output state_t  dbg_state
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int W2    = 2 * WIDTH;
`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  state_t           state, state_n;
  logic [2:0]       op_q;
  logic [W2-1:0]    acc, acc_step, init_mul, prod_fix;
  logic [WIDTH-1:0] opnd, a_mag, b_mag, quo_fix, rem_fix, hi_q, lo_q;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, rneg_q, dz_q, done_q, dz_pulse_q;
  logic             accept, is_mul, is_div, is_mt, sgn, a_neg, b_neg, b_zero;

  always_comb begin
    is_mul = (bus.op[2:1] == 2'b00);
    is_div = (bus.op[2:1] == 2'b01);
    is_mt  = (bus.op == OP_MTHI) || (bus.op == OP_MTLO);
    sgn    = ~bus.op[2] & ~bus.op[0];
    a_neg  = sgn & bus.a[WIDTH-1];
    b_neg  = sgn & bus.b[WIDTH-1];
    a_mag  = a_neg ? -bus.a : bus.a;
    b_mag  = b_neg ? -bus.b : bus.b;
    b_zero = (bus.b == '0);
    accept = bus.start && (state == S_IDLE) && (is_mul || is_div || is_mt);
`ifdef MULDIV_FAST_MULT_EN
    init_mul = W2'(a_mag) * W2'(b_mag);
`else
    init_mul = {{WIDTH{1'b0}}, b_mag};
`endif
    prod_fix = neg_q  ? -acc : acc;
    quo_fix  = neg_q  ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = rneg_q ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) begin
        state_n = (is_mt || (is_div && b_zero) || (is_mul && FAST_MUL)) ? S_FIN : S_RUN;
      end
      S_RUN:   if (cnt == CNT_W'(WIDTH - 1)) state_n = S_FIN;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .is_div  (op_q[1]),
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      acc        <= '0;
      opnd       <= '0;
      cnt        <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
    end else begin
      state      <= state_n;
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          op_q   <= bus.op;
          cnt    <= '0;
          neg_q  <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          dz_q   <= is_div & b_zero;
          opnd   <= is_mul ? a_mag : b_mag;
          acc    <= is_mt ? {{WIDTH{1'b0}}, bus.a} : (is_mul ? init_mul : {{WIDTH{1'b0}}, a_mag});
        end
        S_RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        S_FIN: begin
          done_q     <= 1'b1;
          dz_pulse_q <= dz_q;
          // HI/LO only ever change here, so readers never see half a result
          if (!dz_q) begin
            case (op_q)
              OP_MULT, OP_MULTU: {hi_q, lo_q} <= prod_fix;
              OP_DIV, OP_DIVU: begin
                lo_q <= quo_fix;
                hi_q <= rem_fix;
              end
              OP_MTHI: hi_q <= acc[WIDTH-1:0];
              OP_MTLO: lo_q <= acc[WIDTH-1:0];
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_pulse_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign dbg_state    = state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W    = 32;
  localparam int SB_W = 2 * W + 1;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int              n_checks = 0;
  int              n_errors = 0;
  logic [W-1:0]    m_hi = '0;
  logic [W-1:0]    m_lo = '0;
  logic [SB_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {div_zero, hi, lo} after op, from plain integer arithmetic.
  function automatic logic [SB_W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint       sa, sb, sp;
    logic [63:0]  u;
    logic [W-1:0] h, l;
    logic         dz;
    h  = m_hi;
    l  = m_lo;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b000: begin sp = sa * sb; u = sp; h = u[63:32]; l = u[31:0]; end
      3'b001: begin u = {{W{1'b0}}, a} * {{W{1'b0}}, b}; h = u[63:32]; l = u[31:0]; end
      3'b010: if (b == 0) dz = 1'b1; else begin sp = sa / sb; l = W'(sp); sp = sa % sb; h = W'(sp); end
      3'b011: if (b == 0) dz = 1'b1; else begin l = a / b; h = a % b; end
      3'b100: h = a;
      3'b101: l = a;
      default: ;
    endcase
    return {dz, h, l};
  endfunction

  // Issue at the current negedge, then follow the op to its done pulse.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [SB_W-1:0] e;
    logic [W-1:0]    old_hi, old_lo;
    int              lat, cyc, busy_n;
    bit              changed;
    old_hi  = m_hi;
    old_lo  = m_lo;
    cyc     = 0;
    busy_n  = 0;
    changed = 1'b0;
    exp_q.push_back(model(op, a, b));
    if (op == 3'b100 || op == 3'b101 || ((op == 3'b010 || op == 3'b011) && b == 0)) lat = 2;
    else if (op <= 3'b001) lat = MUL_LAT;
    else lat = DIV_LAT;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom();
    bus.b     = $urandom();
    do begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_n++;
      if (!bus.done && (bus.hi !== old_hi || bus.lo !== old_lo)) changed = 1'b1;
    end while (!bus.done && cyc < 100);
    check("latency", cyc, lat);
    check("busy_cycles", busy_n, lat - 1);
    check("hilo_hold", changed, 0);
    e = exp_q.pop_front();
    check("div_zero", bus.div_zero, e[SB_W-1]);
    check("hi", bus.hi, e[2*W-1:W]);
    check("lo", bus.lo, e[W-1:0]);
    m_hi = e[2*W-1:W];
    m_lo = e[W-1:0];
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_div_zero", bus.div_zero, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_state", dbg_state, S_IDLE);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_max_lo", bus.lo, 32'h0000_0001);
    run_op(OP_MULT, -32'sd3, 32'd7);
    check("mult_neg_lo", bus.lo, 32'hFFFF_FFEB);
    run_op(OP_DIV, -32'sd7, 32'd2);
    check("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'd7, 32'd0);
    check("divu_zero_hi", bus.hi, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'h0);

    // MTHI, with an MTLO request held during its busy cycle: that request is dropped
    bus.start = 1'b1;
    bus.op    = OP_MTHI;
    bus.a     = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.op = OP_MTLO;
    bus.a  = 32'h9ABC_DEF0;
    @(negedge clk);
    check("b2b_busy", bus.busy, 1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("b2b_done", bus.done, 1);
    check("b2b_hi", bus.hi, 32'h1234_5678);
    check("b2b_lo_kept", bus.lo, m_lo);
    m_hi = 32'h1234_5678;
    @(negedge clk);
    check("b2b_dropped_busy", bus.busy, 0);
    check("b2b_dropped_done", bus.done, 0);
    run_op(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
    check("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
    check("mtlo_hi_kept", bus.hi, 32'h1234_5678);

    // Undefined op code: no reaction at all
    bus.start = 1'b1;
    bus.op    = 3'b111;
    bus.a     = $urandom();
    bus.b     = $urandom();
    @(posedge clk);
    #1 bus.start = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy || bus.done) seen = 1'b1;
    end
    check("bad_op_activity", seen, 0);
    check("bad_op_hi", bus.hi, m_hi);
    check("bad_op_lo", bus.lo, m_lo);

    for (int i = 0; i < 24; i++) begin
      logic [2:0] rop;
      rop = 3'($urandom_range(0, 5));
      run_op(rop, pick(), pick());
    end

    // Reset during RUN cycle 10 of a divide
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_hi", bus.hi, 0);
    check("abort_lo", bus.lo, 0);
    m_hi = '0;
    m_lo = '0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    run_op(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
